// File: rtl/armleocpu_defs.sv
// armleocpu_defs
// Definitions shared by the memory arbiter and the cache refill/flush logic:
// the arbiter state encoding and the burstcount decode (0 encodes a full
// 16-beat, 64-byte line).
// No ports (package).
package armleocpu_defs;

    typedef enum logic [1:0] {
        ARB_IDLE        = 2'd0,
        ARB_CMD         = 2'd1,
        ARB_WRITE_BURST = 2'd2,
        ARB_READ_RESP   = 2'd3
    } arb_state_t;

    localparam logic [4:0] BURST_FULL_BEATS = 5'd16;

    function automatic logic [4:0] decode_burstcount(input logic [3:0] bc);
        return (bc == 4'd0) ? BURST_FULL_BEATS : {1'b0, bc};
    endfunction

endpackage

// File: rtl/armleocpu_mem_arbiter.sv
// armleocpu_mem_arbiter
// Shares one burst-capable memory port between the fetch cache (i_*) and the
// data cache (d_*). One owner at a time, held for a whole read or write
// burst, round-robin on ties. Outputs are combinational from the registered
// state/owner plus the owner's pass-through inputs.
//
// State table:
//   state       | meaning
//   ARB_IDLE    | no owner, m_* all zero, both waitrequests high
//   ARB_CMD     | owner's command passes through until accepted
//   ARB_WRITE_BURST | remaining write beats of the owner's burst
//   ARB_READ_RESP   | waiting for the owner's read beats
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_* / d_*  address[33:0], burstcount[3:0], read, write, writedata[31:0],
//              byteenable[3:0] in; waitrequest, readdata[31:0],
//              readdatavalid out
//   m_*        address, burstcount, read, write, writedata, byteenable out;
//              waitrequest, readdata, readdatavalid in
module armleocpu_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [33:0] i_address,
    input  logic [3:0]  i_burstcount,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_writedata,
    input  logic [3:0]  i_byteenable,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    output logic        i_readdatavalid,

    input  logic [33:0] d_address,
    input  logic [3:0]  d_burstcount,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic        d_readdatavalid,

    output logic [33:0] m_address,
    output logic [3:0]  m_burstcount,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    input  logic        m_readdatavalid
);

    import armleocpu_defs::*;

    arb_state_t  r_state;
    logic        r_owner;       // 0 = fetch cache, 1 = data cache
    logic        r_last_grant;
    logic [4:0]  r_count;

    logic        w_i_req;
    logic        w_d_req;
    logic [33:0] w_own_address;
    logic [3:0]  w_own_burstcount;
    logic        w_own_read;
    logic        w_own_write;
    logic [31:0] w_own_writedata;
    logic [3:0]  w_own_byteenable;
    logic        w_own_waitrequest;
    logic        w_own_readdatavalid;
    logic [4:0]  w_beats;

    assign w_i_req = i_read | i_write;
    assign w_d_req = d_read | d_write;

    assign w_own_address    = r_owner ? d_address    : i_address;
    assign w_own_burstcount = r_owner ? d_burstcount : i_burstcount;
    assign w_own_read       = r_owner ? d_read       : i_read;
    assign w_own_write      = r_owner ? d_write      : i_write;
    assign w_own_writedata  = r_owner ? d_writedata  : i_writedata;
    assign w_own_byteenable = r_owner ? d_byteenable : i_byteenable;

    assign w_beats = decode_burstcount(w_own_burstcount);

    always_comb begin
        m_address           = 34'd0;
        m_burstcount        = 4'd0;
        m_read              = 1'b0;
        m_write             = 1'b0;
        m_writedata         = 32'd0;
        m_byteenable        = 4'd0;
        w_own_waitrequest   = 1'b1;
        w_own_readdatavalid = 1'b0;
        case (r_state)
            ARB_CMD: begin
                m_address         = w_own_address;
                m_burstcount      = w_own_burstcount;
                m_read            = w_own_read;
                // read wins when a requester raises both
                m_write           = w_own_write & ~w_own_read;
                m_writedata       = w_own_writedata;
                m_byteenable      = w_own_byteenable;
                w_own_waitrequest = m_waitrequest;
            end
            ARB_WRITE_BURST: begin
                m_address         = w_own_address;
                m_burstcount      = w_own_burstcount;
                m_write           = w_own_write;
                m_writedata       = w_own_writedata;
                m_byteenable      = w_own_byteenable;
                w_own_waitrequest = m_waitrequest;
            end
            ARB_READ_RESP: begin
                w_own_readdatavalid = m_readdatavalid;
            end
            default: begin
            end
        endcase
    end

    assign i_waitrequest   = r_owner ? 1'b1 : w_own_waitrequest;
    assign d_waitrequest   = r_owner ? w_own_waitrequest : 1'b1;
    assign i_readdatavalid = ~r_owner & w_own_readdatavalid;
    assign d_readdatavalid = r_owner & w_own_readdatavalid;
    assign i_readdata      = m_readdata;
    assign d_readdata      = m_readdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b0;
            r_count      <= 5'd0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_i_req | w_d_req) begin
                        r_state <= ARB_CMD;
                        // on a tie the requester that did not go last wins
                        r_owner <= (w_i_req & w_d_req) ? ~r_last_grant : w_d_req;
                    end
                end
                ARB_CMD: begin
                    if (!w_own_read && !w_own_write) begin
                        // abandoned before acceptance: fairness history untouched
                        r_state <= ARB_IDLE;
                    end else if (m_read && !m_waitrequest) begin
                        r_count <= w_beats;
                        r_state <= ARB_READ_RESP;
                    end else if (m_write && !m_waitrequest) begin
                        r_count <= w_beats - 5'd1;
                        if (w_beats == 5'd1) begin
                            r_state      <= ARB_IDLE;
                            r_last_grant <= r_owner;
                        end else begin
                            r_state <= ARB_WRITE_BURST;
                        end
                    end
                end
                ARB_WRITE_BURST: begin
                    if (m_write && !m_waitrequest) begin
                        r_count <= r_count - 5'd1;
                        if (r_count == 5'd1) begin
                            r_state      <= ARB_IDLE;
                            r_last_grant <= r_owner;
                        end
                    end
                end
                ARB_READ_RESP: begin
                    if (m_readdatavalid) begin
                        r_count <= r_count - 5'd1;
                        if (r_count == 5'd1) begin
                            r_state      <= ARB_IDLE;
                            r_last_grant <= r_owner;
                        end
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armleocpu_mem_arbiter.sv
module tb_armleocpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [33:0] i_address, d_address, m_address;
    logic [3:0]  i_burstcount, d_burstcount, m_burstcount;
    logic        i_read, i_write, d_read, d_write, m_read, m_write;
    logic [31:0] i_writedata, d_writedata, m_writedata;
    logic [3:0]  i_byteenable, d_byteenable, m_byteenable;
    logic        i_waitrequest, d_waitrequest, m_waitrequest;
    logic [31:0] i_readdata, d_readdata, m_readdata;
    logic        i_readdatavalid, d_readdatavalid, m_readdatavalid;

    logic        auto_mode, auto_rdv, man_rdv;
    logic [31:0] auto_rdata, man_rdata;
    int          auto_pend;

    assign m_readdatavalid = auto_mode ? auto_rdv   : man_rdv;
    assign m_readdata      = auto_mode ? auto_rdata : man_rdata;

    always #5 clk = ~clk;

    armleocpu_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_address(i_address), .i_burstcount(i_burstcount), .i_read(i_read),
        .i_write(i_write), .i_writedata(i_writedata), .i_byteenable(i_byteenable),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .i_readdatavalid(i_readdatavalid),
        .d_address(d_address), .d_burstcount(d_burstcount), .d_read(d_read),
        .d_write(d_write), .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .d_readdatavalid(d_readdatavalid),
        .m_address(m_address), .m_burstcount(m_burstcount), .m_read(m_read),
        .m_write(m_write), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: who owns the port, which phase ----
    int mo_owner;   // -1 none, 0 fetch, 1 data
    bit mo_cmd;     // command not yet accepted
    bit mo_rd;      // read burst (else write burst) once accepted
    int mo_left;    // beats still expected
    int mo_last;
    int grant_q[$];

    function automatic int beats_of(input logic [3:0] bc);
        return (bc == 4'd0) ? 16 : int'(bc);
    endfunction
    function automatic logic own_read();         return (mo_owner == 1) ? d_read       : i_read;       endfunction
    function automatic logic own_write();        return (mo_owner == 1) ? d_write      : i_write;      endfunction
    function automatic logic [3:0] own_bc();     return (mo_owner == 1) ? d_burstcount : i_burstcount; endfunction
    function automatic logic [33:0] own_addr();  return (mo_owner == 1) ? d_address    : i_address;    endfunction
    function automatic logic [31:0] own_wdata(); return (mo_owner == 1) ? d_writedata  : i_writedata;  endfunction
    function automatic logic [3:0] own_be();     return (mo_owner == 1) ? d_byteenable : i_byteenable; endfunction

    function automatic int seq_code();
        int c;
        c = grant_q.size() << 8;
        foreach (grant_q[k]) c = c | (grant_q[k] << k);
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit r, w;
        bit done;
        if (!rst_n) begin
            mo_owner = -1; mo_cmd = 0; mo_rd = 0; mo_left = 0; mo_last = 0;
        end else begin
            done = 0;
            r = own_read();
            w = own_write();
            if (mo_owner < 0) begin
                if ((i_read | i_write) && (d_read | d_write)) mo_owner = 1 - mo_last;
                else if (d_read | d_write)                    mo_owner = 1;
                else if (i_read | i_write)                    mo_owner = 0;
                if (mo_owner >= 0) begin
                    mo_cmd = 1;
                    grant_q.push_back(mo_owner);
                end
            end else if (mo_cmd) begin
                if (!r && !w) begin
                    mo_owner = -1;
                    mo_cmd   = 0;
                end else if (!m_waitrequest) begin
                    mo_cmd  = 0;
                    mo_rd   = r;
                    mo_left = r ? beats_of(own_bc()) : beats_of(own_bc()) - 1;
                    done    = (mo_left == 0);
                end
            end else if (mo_rd) begin
                if (m_readdatavalid) begin
                    mo_left--;
                    done = (mo_left == 0);
                end
            end else begin
                if (w && !m_waitrequest) begin
                    mo_left--;
                    done = (mo_left == 0);
                end
            end
            if (done) begin
                mo_last  = mo_owner;
                mo_owner = -1;
                mo_rd    = 0;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [33:0] ea;
        logic [3:0]  eb, ebe;
        logic        er, ew, ow, ov;
        logic [31:0] ewd;
        ea = '0; eb = '0; ebe = '0; er = 0; ew = 0; ewd = '0; ow = 1; ov = 0;
        if (mo_owner >= 0) begin
            if (mo_cmd) begin
                ea = own_addr(); eb = own_bc(); er = own_read();
                ew = own_write() & ~own_read(); ewd = own_wdata(); ebe = own_be();
                ow = m_waitrequest;
            end else if (mo_rd) begin
                ov = m_readdatavalid;
            end else begin
                ea = own_addr(); eb = own_bc(); ew = own_write();
                ewd = own_wdata(); ebe = own_be();
                ow = m_waitrequest;
            end
        end
        chk("m_address",    m_address,    ea);
        chk("m_burstcount", m_burstcount, eb);
        chk("m_read",       m_read,       er);
        chk("m_write",      m_write,      ew);
        chk("m_writedata",  m_writedata,  ewd);
        chk("m_byteenable", m_byteenable, ebe);
        chk("i_waitrequest", i_waitrequest, (mo_owner == 0) ? ow : 1'b1);
        chk("d_waitrequest", d_waitrequest, (mo_owner == 1) ? ow : 1'b1);
        chk("i_readdatavalid", i_readdatavalid, (mo_owner == 0) ? ov : 1'b0);
        chk("d_readdatavalid", d_readdatavalid, (mo_owner == 1) ? ov : 1'b0);
        chk("i_readdata", i_readdata, auto_mode ? auto_rdata : man_rdata);
        chk("d_readdata", d_readdata, auto_mode ? auto_rdata : man_rdata);
    end

    // ---------------- observation counters and auto memory responder -------
    int i_rdv_n, d_rdv_n, wr_acc_n;

    always @(negedge clk) begin
        if (rst_n) begin
            if (i_readdatavalid) i_rdv_n++;
            if (d_readdatavalid) d_rdv_n++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && m_write && !m_waitrequest) wr_acc_n++;
    end

    always @(posedge clk or negedge rst_n) begin : responder
        int nxt;
        if (!rst_n) begin
            auto_pend  <= 0;
            auto_rdv   <= 1'b0;
            auto_rdata <= 32'd0;
        end else begin
            nxt = auto_pend - (auto_rdv ? 1 : 0);
            if (auto_mode && m_read && !m_waitrequest) nxt = nxt + beats_of(m_burstcount);
            auto_pend  <= nxt;
            auto_rdv   <= auto_mode && (nxt > 0);
            auto_rdata <= 32'hC0DE_0000 + 32'(nxt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        i_address = '0; i_burstcount = '0; i_read = 0; i_write = 0; i_writedata = '0; i_byteenable = '0;
        d_address = '0; d_burstcount = '0; d_read = 0; d_write = 0; d_writedata = '0; d_byteenable = '0;
        m_waitrequest = 0; man_rdv = 0; man_rdata = '0; auto_mode = 0;
        i_rdv_n = 0; d_rdv_n = 0; wr_acc_n = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_i_wait", i_waitrequest, 1);
        chk("rst_d_wait", d_waitrequest, 1);
        chk("rst_m_read", m_read, 0);
        rst_n = 1;
        tick();

        // simultaneous read after reset: data cache first, then fetch
        grant_q.delete();
        i_address = 34'h200; i_burstcount = 4'd2; i_read = 1;
        d_address = 34'h300; d_burstcount = 4'd2; d_read = 1;
        tick();
        chk("tie_m_read", m_read, 1);
        chk("tie_addr_d", m_address, 34'h300);
        chk("tie_i_wait", i_waitrequest, 1);
        tick();
        d_read = 0;
        man_rdv = 1; man_rdata = 32'h1; tick();
        man_rdata = 32'h2; tick();
        man_rdv = 0;
        chk("tie_gap_m_read", m_read, 0);
        tick();
        chk("tie_i_addr", m_address, 34'h200);
        chk("tie_i_read", m_read, 1);
        tick();
        i_read = 0;
        man_rdv = 1; tick(); tick();
        man_rdv = 0;
        tick();
        chk("tie_grants", seq_code(), 32'h201);

        // single 16-beat read from the data cache
        grant_q.delete();
        i_rdv_n = 0; d_rdv_n = 0;
        d_address = 34'h100; d_burstcount = 4'd0; d_read = 1;
        tick();
        chk("single_addr", m_address, 34'h100);
        chk("single_d_wait", d_waitrequest, 0);
        tick();
        d_read = 0;
        for (int k = 0; k < 16; k++) begin
            man_rdv = 1; man_rdata = 32'hA000 + 32'(k);
            tick();
        end
        man_rdv = 0;
        tick();
        chk("single_d_beats", d_rdv_n, 16);
        chk("single_i_beats", i_rdv_n, 0);
        chk("single_end_wait", d_waitrequest, 1);

        // round-robin with both requesters holding requests
        grant_q.delete();
        i_burstcount = 4'd1; d_burstcount = 4'd1;
        auto_mode = 1;
        i_read = 1; d_read = 1;
        repeat (12) tick();
        i_read = 0; d_read = 0;
        repeat (3) tick();
        auto_mode = 0;
        chk("rr_grants", seq_code(), 32'h40A);

        // write burst of 4 with stalls on beats 1 and 3
        wr_acc_n = 0;
        i_address = 34'h400; i_burstcount = 4'd4; i_byteenable = 4'hF;
        i_writedata = 32'h1111_0000; i_write = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            i_writedata = 32'h1111_0000 + 32'(k);
            if (k == 0 || k == 2) begin
                m_waitrequest = 1;
                tick();
                m_waitrequest = 0;
            end
            tick();
        end
        i_write = 0;
        tick();
        chk("wr_beats", wr_acc_n, 4);
        chk("wr_end_wait", i_waitrequest, 1);

        // spurious read beat while idle
        i_rdv_n = 0; d_rdv_n = 0;
        man_rdata = 32'hDEADBEEF; man_rdv = 1;
        tick();
        chk("spur_i_rdv", i_readdatavalid, 0);
        chk("spur_d_rdv", d_readdatavalid, 0);
        chk("spur_bcast", d_readdata, 32'hDEADBEEF);
        man_rdv = 0;
        tick();
        chk("spur_counts", i_rdv_n + d_rdv_n, 0);

        // reset in the middle of a 16-beat read
        d_address = 34'h500; d_burstcount = 4'd0; d_read = 1;
        tick();
        tick();
        d_read = 0;
        d_rdv_n = 0;
        for (int k = 0; k < 5; k++) begin
            man_rdv = 1; man_rdata = 32'hB000 + 32'(k);
            tick();
        end
        #2;
        rst_n = 0;
        #1;
        chk("rstmid_d_rdv", d_readdatavalid, 0);
        chk("rstmid_d_wait", d_waitrequest, 1);
        chk("rstmid_m_bc", m_burstcount, 0);
        chk("rstmid_beats", d_rdv_n, 5);
        man_rdv = 0;
        tick();
        rst_n = 1;
        tick();
        i_address = 34'h600; i_burstcount = 4'd1; i_read = 1;
        tick();
        chk("post_rst_read", m_read, 1);
        chk("post_rst_addr", m_address, 34'h600);
        chk("post_rst_i_wait", i_waitrequest, 0);
        tick();
        i_read = 0;
        man_rdv = 1; tick();
        man_rdv = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
